seq_div32: RTL and testbench
============================

# seq_div32

Sequential radix-2 non-restoring divider for the basic arithmetic library. It is the inverse companion to the team's sequential Booth multiplier. It takes a dividend and a divisor on a `start` pulse and iterates one quotient bit per clock. When finished it presents the quotient and remainder with a one-cycle `done` pulse. It is intended as the divide unit beside the multiplier in the CPU execute stage, and as a self-check partner for it: (a*b)/b == a.

## Interface
Parameters:
- `WIDTH`, default 32: operand, quotient and remainder width. The iteration counter is `$clog2(WIDTH)+1` bits.

Ports:
- `clk`, input, 1: sole clock. All logic is on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: load operands and begin a divide. Accepted only in IDLE or DONE.
- `dividend`, input, WIDTH: dividend, sampled on the accepting edge only.
- `divisor`, input, WIDTH: divisor, sampled on the accepting edge only.
- `quot`, output, WIDTH: quotient, registered and held until the next accepted `start`.
- `rem`, output, WIDTH: remainder, registered and held until the next accepted `start`.
- `busy`, output, 1: high in CALC and FIX.
- `done`, output, 1: one-cycle pulse in DONE.
- `div_zero`, output, 1: high with `done` when the divisor was 0. Held until the next accepted `start`.

## Operation
- States:
  - IDLE
  - CALC, for WIDTH iterations
  - FIX, for remainder and sign correction
  - DONE, lasting 1 cycle
- Transitions:
  - IDLE/DONE to CALC on `start` with a nonzero divisor.
  - IDLE/DONE to DONE on `start` with divisor 0.
  - CALC to FIX when the counter reaches WIDTH-1.
  - FIX to DONE.
  - DONE to IDLE when `start` is low.
- Load: partial remainder P = 0 (WIDTH+1 bits), Q = |dividend|, D = |divisor|, counter = 0. Without the signed feature, the magnitudes are the raw operand values.
- CALC step, once per cycle:
  - Shift {P,Q} left one bit.
  - If P ≥ 0, P = P − D; otherwise P = P + D.
  - Q[0] = ~P_new[WIDTH].
- FIX:
  - If P < 0, P = P + D.
  - Apply signs, then register `quot`/`rem`.
- Division by zero: `quot` = all ones, `rem` = dividend. No iterations are run.
- `start` during CALC or FIX is ignored. The operation in flight is not disturbed.
- All arithmetic is WIDTH+1-bit two's complement. Carries out of WIDTH+1 bits are discarded.

## Timing
- Reset values:
  - `quot` = 0 and `rem` = 0.
  - `busy` = 0, `done` = 0 and `div_zero` = 0.
  - State = IDLE.
- `rst` has priority over `start`. Asserting `rst` mid-operation aborts it on that edge with no `done` pulse.
- Normal latency: `start` sampled at edge 0 gives CALC on edges 1..WIDTH, FIX on edge WIDTH+1, and `done`=1 in the cycle after edge WIDTH+1. For WIDTH=32, `done` is high 34 cycles after the start edge.
- Divide-by-zero latency: `done` and `div_zero` are high in the cycle after the start edge.
- `busy` rises the cycle after the start edge and falls in the same cycle that `done` rises.
- A `start` held high in DONE restarts immediately, giving back-to-back operation with no IDLE cycle.
- `quot`/`rem` change only on the FIX→DONE edge, or on a load into DONE for divide-by-zero.

## Configuration
- `SEQ_DIV_SIGNED_EN` defined: operands are two's-complement signed.
  - Magnitudes are taken at load.
  - Quotient is negated if the operand signs differ, truncating toward zero.
  - Remainder takes the sign of the dividend.
  - Overflow case −2^(WIDTH−1) / −1 gives `quot` = −2^(WIDTH−1) and `rem` = 0.
- Not defined: operands are unsigned only. There is no sign logic, and FIX performs only the remainder restore.

## Structure
- Package `div_pkg` contains:
  - the state enum (IDLE, CALC, FIX, DONE);
  - `DIV_WIDTH_DEF` = 32;
  - the divide-by-zero quotient constant (all ones).
- Sub-module `addsub`: a (WIDTH+1)-bit adder with a `sub` control (b inverted, carry-in = `sub`). One instance is shared by CALC and FIX.

## Test plan
- dividend=390, divisor=13: `quot`=30, `rem`=0. `done` rises exactly 34 cycles after the start edge, and `busy` is high for 33 cycles.
- dividend=100, divisor=7: `quot`=14, `rem`=2. dividend=0xFFFFFFFF, divisor=1 (unsigned build): `quot`=0xFFFFFFFF, `rem`=0.
- dividend=55, divisor=0: `done`=1 and `div_zero`=1 one cycle after start. `quot`=0xFFFFFFFF, `rem`=55.
- Signed build:
  - −7/2 gives `quot`=−3, `rem`=−1.
  - 7/−2 gives `quot`=−3, `rem`=1.
  - 0x80000000/−1 gives `quot`=0x80000000, `rem`=0.
- 100/7 in flight with `start` pulsed at cycle 10 carrying 9/3: the pulse is ignored and the result is 14 r 2. `rst` asserted at cycle 20 of a new divide: all outputs are 0, and `done` never pulses.
- Back-to-back: `start` held through DONE with 390/13 then 100/7 gives two `done` pulses 34 cycles apart with correct results.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam int DIV_WIDTH_DEF = 32;

  localparam logic [DIV_WIDTH_DEF-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/addsub.sv
// Shared adder/subtractor: sum = a + (sub ? ~b + 1 : b).
module addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  assign sum = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/seq_div32.sv
// Radix-2 non-restoring divider, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement signed operands.
module seq_div32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t state, state_nx;

  logic [WIDTH:0]   p;
  logic [WIDTH:0]   as_a;
  logic [WIDTH:0]   as_b;
  logic [WIDTH:0]   as_sum;
  logic             as_sub;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             dz;
  logic             last;

  assign accept = start && (state == IDLE || state == DONE);
  assign dz     = (divisor == '0);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);

  // After the last step P is in [-D, D); a negative P needs D added back.
  assign rem_mag = p[WIDTH] ? as_sum[WIDTH-1:0] : p[WIDTH-1:0];

`ifdef SEQ_DIV_SIGNED_EN
  logic sgn_a;
  logic sgn_b;
  logic neg_q;
  logic neg_r;

  assign sgn_a    = dividend[WIDTH-1];
  assign sgn_b    = divisor[WIDTH-1];
  assign mag_a    = sgn_a ? WIDTH'(0) - dividend : dividend;
  assign mag_b    = sgn_b ? WIDTH'(0) - divisor : divisor;
  assign quot_fix = neg_q ? WIDTH'(0) - q : q;
  assign rem_fix  = neg_r ? WIDTH'(0) - rem_mag : rem_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sgn_a ^ sgn_b;
      neg_r <= sgn_a;
    end
  end
`else
  assign mag_a    = dividend;
  assign mag_b    = divisor;
  assign quot_fix = q;
  assign rem_fix  = rem_mag;
`endif

  always_comb begin
    as_a   = {p[WIDTH-1:0], q[WIDTH-1]};
    as_b   = {1'b0, d};
    as_sub = ~p[WIDTH];
    if (state == FIX) begin
      as_a   = p;
      as_sub = 1'b0;
    end
  end

  addsub #(
    .W(WIDTH + 1)
  ) u_addsub (
    .a  (as_a),
    .b  (as_b),
    .sub(as_sub),
    .sum(as_sum)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = dz ? DONE : CALC;
      CALC: if (last) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: begin
        if (start) state_nx = dz ? DONE : CALC;
        else       state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      p        <= '0;
      q        <= '0;
      d        <= '0;
      cnt      <= '0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        if (dz) begin
          quot     <= WIDTH'(DIV_ZERO_QUOT);
          rem      <= dividend;
          div_zero <= 1'b1;
        end else begin
          p        <= '0;
          q        <= mag_a;
          d        <= mag_b;
          cnt      <= '0;
          div_zero <= 1'b0;
        end
      end else if (state == CALC) begin
        p   <= as_sum;
        q   <= {q[WIDTH-2:0], ~as_sum[WIDTH]};
        cnt <= cnt + 1'b1;
      end else if (state == FIX) begin
        quot <= quot_fix;
        rem  <= rem_fix;
      end
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
// Scoreboard bench for seq_div32: directed vectors, decoupled monitor.
module tb_seq_div32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        busy;
  logic        done;
  logic        div_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_div32 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dividend(dividend),
    .divisor (divisor),
    .quot    (quot),
    .rem     (rem),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done got=1 want=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_quot"}, quot, e.q);
        chk({e.nm, "_rem"}, rem, e.r);
        chk({e.nm, "_dz"}, {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  task automatic push(input logic [31:0] q, input logic [31:0] r,
                      input logic dz, input string nm);
    exp_t e;
    e.q  = q;
    e.r  = r;
    e.dz = dz;
    e.nm = nm;
    sb.push_back(e);
  endtask

  // One divide; checks done latency and busy length
  task automatic run(input string nm, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eq,
                     input logic [31:0] er, input logic edz,
                     input int elat, input int ebusy);
    int n;
    int bc;
    push(eq, er, edz, nm);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    n  = 0;
    bc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) bc++;
    end while (!done && n < 100);
    chk({nm, "_lat"}, n, elat);
    chk({nm, "_busy"}, bc, ebusy);
  endtask

  initial begin
    int n;
    int dc;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_flags", {29'd0, busy, done, div_zero}, 0);
    rst = 1'b0;

    run("d390_13", 390, 13, 30, 0, 1'b0, 34, 33);
    run("d100_7", 100, 7, 14, 2, 1'b0, 34, 33);
    run("dz55", 55, 0, 32'hFFFF_FFFF, 55, 1'b1, 1, 0);
`ifdef SEQ_DIV_SIGNED_EN
    run("s_m7_2", 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 33);
    run("s_7_m2", 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 1'b0, 34, 33);
    run("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0, 34, 33);
`else
    run("u_max_1", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 1'b0, 34, 33);
    run("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1'b0, 34, 33);
`endif

    // start pulse mid-flight must be ignored
    push(14, 2, 1'b0, "ign");
    @(negedge clk);
    dividend = 100;
    divisor  = 7;
    start    = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = (n == 10);
      if (n == 10) begin
        dividend = 9;
        divisor  = 3;
      end
    end while (!done && n < 100);
    start = 1'b0;
    chk("ign_lat", n, 34);

    // reset mid-divide aborts with no done pulse
    @(negedge clk);
    dividend = 390;
    divisor  = 13;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quot", quot, 0);
    chk("abort_rem", rem, 0);
    chk("abort_flags", {29'd0, busy, done, div_zero}, 0);
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("abort_nodone", dc, 0);

    // back-to-back: start held through DONE
    push(30, 0, 1'b0, "b2b1");
    push(14, 2, 1'b0, "b2b2");
    @(negedge clk);
    dividend = 390;
    divisor  = 13;
    start    = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    chk("b2b1_lat", n, 34);
    dividend = 100;
    divisor  = 7;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!done && n < 100);
    chk("b2b2_gap", n, 34);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
